// File: rtl/riscv_fetch_unit_if.sv
// rtl/riscv_fetch_unit_if.sv - fetch unit bus: imem request/response, redirect, instruction output
interface riscv_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;
    logic        fetched_pulse;
    logic [31:0] fetch_count;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, out_ready,
        output out_valid, out_instr, out_pc, out_fault, fetched_pulse, fetch_count
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, out_ready,
        input  out_valid, out_instr, out_pc, out_fault, fetched_pulse, fetch_count
    );
endinterface

// File: rtl/riscv_fetch_unit.sv
// rtl/riscv_fetch_unit.sv - instruction fetch stage: PC, single-outstanding imem reads, redirects
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    riscv_fetch_unit_if.master         bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP, S_FAULT, S_STALL
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        pulse_q, pulse_d;
    logic [31:0] count_q, count_d;
    logic        stale_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            pulse_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            pulse_q     <= pulse_d;
            count_q     <= count_d;
        end
    end

    // A request is still owed a response: the redirect must go through DROP to swallow it.
    assign stale_req = (state_q == S_REQ  &&  bus.imem_req_ready) ||
                       (state_q == S_WAIT && !bus.imem_rsp_valid) ||
                       (state_q == S_DROP && !bus.imem_rsp_valid);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        pulse_d     = 1'b0;
        count_d     = count_q;

        if ((state_q == S_HOLD || state_q == S_FAULT) && bus.out_ready)
            count_d = count_q + 32'd1;

        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
            if (stale_req) begin
                state_d = S_DROP;
            end else if (bus.redirect_pc[1:0] != 2'b00) begin
                state_d     = S_FAULT;
                out_pc_d    = bus.redirect_pc;
                out_instr_d = '0;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ:  if (bus.imem_req_ready) state_d = S_WAIT;
                S_WAIT: if (bus.imem_rsp_valid) begin
                    out_instr_d = bus.imem_rsp_data;
                    out_pc_d    = pc_q;
                    pc_d        = pc_q + 32'd4;
                    pulse_d     = 1'b1;
                    state_d     = S_HOLD;
                end
                S_HOLD: if (bus.out_ready) state_d = S_REQ;
                S_DROP: if (bus.imem_rsp_valid) begin
                    if (pc_q[1:0] != 2'b00) begin
                        state_d     = S_FAULT;
                        out_pc_d    = pc_q;
                        out_instr_d = '0;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_FAULT: if (bus.out_ready) state_d = S_STALL;
                S_STALL: state_d = S_STALL;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.imem_req_valid = (state_q == S_REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.out_valid      = (state_q == S_HOLD) || (state_q == S_FAULT);
    assign bus.out_fault      = (state_q == S_FAULT);
    assign bus.out_instr      = out_instr_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.fetched_pulse  = pulse_q;
    assign bus.fetch_count    = count_q;
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb/tb_riscv_fetch_unit.sv - randomized scoreboard bench for riscv_fetch_unit
module tb_riscv_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0400;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic mem_en;
    int   n_pass = 0;
    int   n_total = 0;
    int   hs_cnt = 0;
    exp_t exp_q[$];

    riscv_fetch_unit_if bus();

    riscv_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference: after a redirect to t the consumer sees t, t+4, ... (mod 2^32) with memory
    // contents, or a single fault item at t when t is misaligned, then nothing.
    task automatic push_stream(input logic [31:0] t);
        exp_t e;
        exp_q.delete();
        if (t[1:0] != 2'b00) begin
            e.pc = t; e.instr = 32'h0; e.fault = 1'b1;
            exp_q.push_back(e);
        end else begin
            for (int i = 0; i < 256; i++) begin
                e.pc = t + 32'(4 * i); e.instr = mem_word(e.pc); e.fault = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_redirect(input logic [31:0] t);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = t;
        @(negedge clk); #1;
        push_stream(t);
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick_target();
        int r;
        r = $urandom_range(0, 15);
        if (r < 2)  return ($urandom & 32'h0000_0FFC) | 32'($urandom_range(1, 3));
        if (r == 2) return 32'hFFFF_FFF0;
        return $urandom & 32'h0000_0FFC;
    endfunction

    task automatic check_reset_values();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_req_addr",  bus.imem_req_addr, RESET_PC);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_instr", bus.out_instr, 32'h0);
        chk("rst_out_pc",    bus.out_pc, 32'h0);
        chk("rst_out_fault", 32'(bus.out_fault), 32'h0);
        chk("rst_pulse",     32'(bus.fetched_pulse), 32'h0);
        chk("rst_count",     bus.fetch_count, 32'h0);
    endtask

    // Memory model: accepts on valid&ready, answers 1..3 cycles later with mem_word(addr).
    initial begin
        logic        acc, pend;
        logic [31:0] acc_addr, pend_addr;
        int          dly;
        pend = 1'b0; dly = 0; pend_addr = 0;
        forever begin
            @(negedge clk);
            acc      = mem_en && !reset && bus.imem_req_valid && bus.imem_req_ready;
            acc_addr = bus.imem_req_addr;
            @(posedge clk); #1;
            if (mem_en) begin
                bus.imem_rsp_valid = 1'b0;
                if (acc) begin pend = 1'b1; pend_addr = acc_addr; dly = $urandom_range(0, 2); end
                if (pend) begin
                    if (dly == 0) begin
                        bus.imem_rsp_valid = 1'b1;
                        bus.imem_rsp_data  = mem_word(pend_addr);
                        pend = 1'b0;
                    end else dly--;
                end
                bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            end else pend = 1'b0;
        end
    end

    // Monitor: scoreboard pops on every handshake; held outputs must stay put while stalled.
    logic        have_prev;
    logic [31:0] prev_pc, prev_instr;
    logic        prev_fault;
    always @(negedge clk) begin
        if (reset) begin
            hs_cnt    = 0;
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                chk("hold_valid",   32'(bus.out_valid), 32'h1);
                chk("hold_pc",      bus.out_pc, prev_pc);
                chk("hold_instr",   bus.out_instr, prev_instr);
                chk("hold_fault",   32'(bus.out_fault), 32'(prev_fault));
                chk("hold_noreq",   32'(bus.imem_req_valid), 32'h0);
            end
            have_prev  = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
            prev_pc    = bus.out_pc;
            prev_instr = bus.out_instr;
            prev_fault = bus.out_fault;
            if (bus.fetched_pulse)
                chk("pulse_with_hold", {30'h0, bus.out_valid, bus.out_fault}, 32'h2);
            if (bus.imem_req_valid)
                chk("req_addr_align", {30'h0, bus.imem_req_addr[1:0]}, 32'h0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_out: got pc %h, expected no output", bus.out_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_pc",    bus.out_pc, e.pc);
                    chk("out_instr", bus.out_instr, e.instr);
                    chk("out_fault", 32'(bus.out_fault), 32'(e.fault));
                end
                chk("fetch_count", bus.fetch_count, 32'(hs_cnt));
                hs_cnt++;
            end
        end
    end

    initial begin
        logic ok;
        int   hs_start;
        reset = 1'b1; mem_en = 1'b1;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.out_ready = 1'b0;
        #12;
        check_reset_values();
        @(posedge clk); #1;
        reset = 1'b0;
        push_stream(RESET_PC);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 19) == 0) do_redirect(pick_target());
        end
        chk("random_progress", 32'(hs_cnt > 100), 32'h1);

        // Park in HOLD on 0x300, then stop the memory model and drive the bus by hand.
        bus.out_ready = 1'b0;
        do_redirect(32'h0000_0300);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.out_valid && !bus.out_fault) begin ok = 1'b1; break; end
        end
        chk("reach_hold", 32'(ok), 32'h1);
        mem_en = 1'b0;
        @(posedge clk); #1;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.imem_req_valid) begin ok = 1'b1; break; end
        end
        chk("req_after_hs", 32'(ok), 32'h1);
        chk("req_addr_304", bus.imem_req_addr, 32'h0000_0304);
        @(posedge clk); #1;
        bus.imem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.imem_req_ready = 1'b0;
        @(negedge clk);
        chk("in_wait_noreq", 32'(bus.imem_req_valid), 32'h0);
        #1 reset = 1'b1;
        #1 check_reset_values();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("stale_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("stale_req_addr",  bus.imem_req_addr, RESET_PC);
        chk("stale_out_valid", 32'(bus.out_valid), 32'h0);
        chk("stale_pulse",     32'(bus.fetched_pulse), 32'h0);
        @(posedge clk); #1;
        bus.imem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("stale_pulse2",    32'(bus.fetched_pulse), 32'h0);
        chk("stale_out_valid2", 32'(bus.out_valid), 32'h0);
        chk("stale_still_req", 32'(bus.imem_req_valid), 32'h1);
        #1;
        push_stream(RESET_PC);
        mem_en = 1'b1;
        hs_start = hs_cnt;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        chk("post_reset_progress", 32'(hs_cnt - hs_start >= 10), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
